// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the off-chip memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntI = 1'b0,
    GntD = 1'b1
  } grant_e;

  localparam int unsigned DefaultMemLat    = 6;
  localparam int unsigned DefaultLineWords = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing one memory access; holds at zero until reloaded.
module mem_lat_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refill and D-cache refill/write-back.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_WORDS = DefaultLineWords,
  parameter int unsigned MEM_LAT    = DefaultMemLat,
  localparam int unsigned LINE_W    = DATA_W * LINE_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              mem_busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic              grant;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are only looked at in IDLE; on a tie the side not served last wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_req && d_req) begin
          state_d = (last_grant_q == GntI) ? StBusyD : StBusyI;
        end else if (i_req) begin
          state_d = StBusyI;
        end else if (d_req) begin
          state_d = StBusyD;
        end
      end
      StBusyI, StBusyD: begin
        if (cnt_zero) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant = (state_q == StIdle) && (state_d != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GntI;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else if (grant) begin
      if (state_d == StBusyI) begin
        last_grant_q <= GntI;
        addr_q       <= i_addr;
        we_q         <= 1'b0;
      end else begin
        last_grant_q <= GntD;
        addr_q       <= d_addr;
        we_q         <= d_we;
        wdata_q      <= d_wdata;
      end
    end
  end

  mem_lat_counter #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (grant),
    .load_val (CNT_W'(MEM_LAT - 1)),
    .dec      (state_q != StIdle),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    i_done    = 1'b0;
    d_done    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_busy  = 1'b0;
    unique case (state_q)
      StBusyI: begin
        mem_busy = 1'b1;
        mem_read = 1'b1;
        mem_addr = addr_q;
        i_done   = cnt_zero;
      end
      StBusyD: begin
        mem_busy  = 1'b1;
        mem_read  = !we_q;
        mem_write = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        d_done    = cnt_zero;
      end
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MEM_LAT  = 6;
  localparam int ADDR_W   = 16;
  localparam int LINE_W   = 64;
  localparam int WAIT_MAX = 2 * MEM_LAT + 2;

  logic              clk;
  logic              reset_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_busy;

  int tests = 0;
  int fails = 0;
  int i_wait = 0;
  int d_wait = 0;
  bit random_mode = 0;

  // Reference model: who owns the port, cycles left, and what was captured at grant.
  int                m_owner;  // 0 none, 1 I, 2 D
  int                m_left;
  int                m_last;   // 1 I, 2 D
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [LINE_W-1:0] m_wdata;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (16),
    .LINE_WORDS (4),
    .MEM_LAT    (MEM_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    m_owner = 0; m_left = 0; m_last = 1;
    m_addr = '0; m_we = 1'b0; m_wdata = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_owner = 0; m_left = 0; m_last = 1;
      end else if (m_owner != 0) begin
        if (m_left == 0) m_owner = 0;
        else m_left--;
      end else if (i_req || d_req) begin
        if (i_req && d_req) m_owner = (m_last == 1) ? 2 : 1;
        else m_owner = i_req ? 1 : 2;
        m_left = MEM_LAT - 1;
        m_last = m_owner;
        m_addr = (m_owner == 1) ? i_addr : d_addr;
        m_we   = (m_owner == 2) && d_we;
        if (m_owner == 2) m_wdata = d_wdata;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_eq("mem_busy", mem_busy, m_owner != 0);
      check_eq("mem_read", mem_read, (m_owner == 1) || (m_owner == 2 && !m_we));
      check_eq("mem_write", mem_write, m_owner == 2 && m_we);
      check_eq("i_done", i_done, m_owner == 1 && m_left == 0);
      check_eq("d_done", d_done, m_owner == 2 && m_left == 0);
      check_eq("done_overlap", i_done & d_done, 0);
      if (m_owner != 0) check_eq("mem_addr", mem_addr, m_addr);
      if (m_owner == 2 && m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
      if (i_done) check_eq("i_rdata", i_rdata, mem_rdata);
      if (d_done) check_eq("d_rdata", d_rdata, mem_rdata);
      if (!reset_n) begin
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
      end
    end
  end

  // One clock of requester behaviour: drop req the edge after done, optionally raise/jitter.
  task automatic step();
    logic idone, ddone;
    @(negedge clk);
    idone = i_done;
    ddone = d_done;
    if (!reset_n) begin
      i_wait = 0;
      d_wait = 0;
    end else begin
      if (i_req) i_wait++;
      if (d_req) d_wait++;
    end
    if (idone) check_eq("i_wait_bound", i_wait <= WAIT_MAX, 1);
    if (ddone) check_eq("d_wait_bound", d_wait <= WAIT_MAX, 1);
    @(posedge clk);
    #1;
    if (idone) begin i_req = 1'b0; i_wait = 0; end
    if (ddone) begin d_req = 1'b0; d_wait = 0; end
    if (random_mode) begin
      if (!i_req && !idone && $urandom_range(2) == 0) begin
        i_req  = 1'b1;
        i_addr = ADDR_W'($urandom);
      end else if (i_req && $urandom_range(7) == 0) begin
        i_addr = ADDR_W'($urandom);
      end
      if (!d_req && !ddone && $urandom_range(2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom);
        d_addr  = ADDR_W'($urandom);
        d_wdata = {$urandom, $urandom};
      end else if (d_req && $urandom_range(7) == 0) begin
        d_addr  = ADDR_W'($urandom);
        d_wdata = {$urandom, $urandom};
      end
    end
    mem_rdata = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      step();
      if (!i_req && !d_req && !mem_busy) done = 1;
    end
    check_eq(tag, done, 1);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = 64'h0123_4567_89ab_cdef;
    #1;
    check_eq("rst_i_rdata", i_rdata, 64'h0123_4567_89ab_cdef);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Lone instruction read.
    i_req = 1'b1; i_addr = 16'h0040;
    wait_idle("lone_i_timeout");

    // Lone data write-back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 64'h1111_2222_3333_4444;
    wait_idle("lone_d_timeout");

    // Simultaneous requests straight after reset: D must go first.
    pulse_reset();
    i_req = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    wait_idle("tie_timeout");

    // Reset during the third cycle of an I access; held req is re-issued afterwards.
    i_req = 1'b1; i_addr = 16'h0040;
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_eq("abort_mem_read", mem_read, 0);
    check_eq("abort_mem_busy", mem_busy, 0);
    check_eq("abort_i_done", i_done, 0);
    step();
    reset_n = 1'b1;
    wait_idle("reissue_timeout");

    // Address change mid-access must not reach the memory port.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    step();
    step();
    step();
    d_addr = 16'h0200;
    wait_idle("addr_hold_timeout");

    random_mode = 1;
    for (int n = 0; n < 1500; n++) step();
    random_mode = 0;
    wait_idle("random_drain_timeout");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
